// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states, legal
// parameter ranges and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    localparam int MIN_CLKS_PER_BIT = 8;
    localparam int MIN_DATA_BITS    = 5;
    localparam int MAX_DATA_BITS    = 9;

    // Expected parity bit for a zero-extended data word.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial input and received-frame outputs of the configurable UART receiver.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 in_serial_rx;
    logic                 out_dataV;
    logic [DATA_BITS-1:0] out_byte_Rx;
    logic                 out_parity_err;
    logic                 out_frame_err;
    logic                 out_break;

    modport slave (
        input  in_serial_rx,
        output out_dataV, out_byte_Rx, out_parity_err, out_frame_err, out_break
    );

    modport master (
        output in_serial_rx,
        input  out_dataV, out_byte_Rx, out_parity_err, out_frame_err, out_break
    );
endinterface

// File: rtl/uart_bit_sampler.sv
// Input synchroniser, bit-period counter and 3-sample majority vote.
// o_bit is valid in the cycle o_bit_tick is high (count MID+1).
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic i_serial,
    input  logic i_run,
    output logic o_rx_s,
    output logic o_bit_tick,
    output logic o_bit_wrap,
    output logic o_bit
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_clks
            $error("uart_bit_sampler: CLKS_PER_BIT below minimum");
        end
    endgenerate

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_s0;
    logic             r_s1;
    logic             w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_serial};
            if (!i_run || r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_run && r_cnt == CNT_S0) r_s0 <= w_rx_s;
            if (i_run && r_cnt == CNT_S1) r_s1 <= w_rx_s;
        end
    end

    assign o_rx_s     = w_rx_s;
    assign o_bit_tick = i_run && (r_cnt == CNT_DEC);
    assign o_bit_wrap = i_run && (r_cnt == CNT_LAST);
    assign o_bit      = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM on top of the bit sampler, with
// parity, frame-error and break reporting registered on the valid pulse.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input logic          in_clk,
    input logic          in_rst_n,
    uart_rx_cfg_if.slave rx_if
);
    localparam int IDX_W = $clog2(MAX_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    generate
        if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
            $error("uart_rx_cfg: illegal DATA_BITS or STOP_BITS");
        end
    endgenerate

    state_t               r_state;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_bit;
    logic                 r_stop_err;
    logic                 r_all_zero;
    logic                 r_data_v;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_break;

    logic                     w_run;
    logic                     w_rx_s;
    logic                     w_tick;
    logic                     w_wrap;
    logic                     w_bit;
    logic                     w_parity_err;
    logic [MAX_DATA_BITS-1:0] w_data_ext;

    assign w_run = (r_state != ST_IDLE) && (r_state != ST_WAIT_IDLE);

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .i_serial  (rx_if.in_serial_rx),
        .i_run     (w_run),
        .o_rx_s    (w_rx_s),
        .o_bit_tick(w_tick),
        .o_bit_wrap(w_wrap),
        .o_bit     (w_bit)
    );

    always_comb begin
        w_data_ext                 = '0;
        w_data_ext[DATA_BITS-1:0]  = r_data;
    end

    assign w_parity_err = (PARITY_EN != 0) &&
                          (parity_calc(w_data_ext, PARITY_ODD != 0) != r_par_bit);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_data       <= '0;
            r_par_bit    <= 1'b0;
            r_stop_err   <= 1'b0;
            r_all_zero   <= 1'b0;
            r_data_v     <= 1'b0;
            r_byte       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break      <= 1'b0;
        end else begin
            r_data_v <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_stop_err <= 1'b0;
                    r_all_zero <= 1'b1;
                    if (!w_rx_s) r_state <= ST_START;
                end
                ST_START: begin
                    if (w_tick && w_bit) begin
                        r_state <= ST_IDLE;
                    end else if (w_wrap) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
                    if (w_tick) begin
                        r_data <= {w_bit, r_data[DATA_BITS-1:1]};
                        if (w_bit) r_all_zero <= 1'b0;
                    end
                    if (w_wrap) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_par_bit <= w_bit;
                        if (w_bit) r_all_zero <= 1'b0;
                    end
                    if (w_wrap) r_state <= ST_STOP;
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_stop_idx == LAST_STOP) begin
                            r_data_v     <= 1'b1;
                            r_byte       <= r_data;
                            r_parity_err <= w_parity_err;
                            r_frame_err  <= r_stop_err | ~w_bit;
                            r_break      <= r_all_zero & ~w_bit;
                            // Leave mid-stop-bit on a good stop to gain resync margin.
                            r_state      <= w_bit ? ST_IDLE : ST_WAIT_IDLE;
                        end else if (!w_bit) begin
                            r_stop_err <= 1'b1;
                        end else begin
                            r_all_zero <= 1'b0;
                        end
                    end
                    if (w_wrap) r_stop_idx <= r_stop_idx + 1'b1;
                end
                ST_WAIT_IDLE: begin
                    if (w_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.out_dataV      = r_data_v;
    assign rx_if.out_byte_Rx    = r_byte;
    assign rx_if.out_parity_err = r_parity_err;
    assign rx_if.out_frame_err  = r_frame_err;
    assign rx_if.out_break      = r_break;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised self-checking bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2)
// checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int C   = 16;
    localparam int MID = (C - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] line = 3'b111;
    int         edge_cnt = 0;
    int         start_edge = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_c ();

    assign if_a.in_serial_rx = line[0];
    assign if_b.in_serial_rx = line[1];
    assign if_c.in_serial_rx = line[2];

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut_a (.in_clk(clk), .in_rst_n(rst_n), .rx_if(if_a));
    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut_b (.in_clk(clk), .in_rst_n(rst_n), .rx_if(if_b));
    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        dut_c (.in_clk(clk), .in_rst_n(rst_n), .rx_if(if_c));

    logic [2:0] dv;
    logic [2:0] operr;
    logic [2:0] oferr;
    logic [2:0] obrk;
    logic [7:0] obyte [3];

    assign dv    = {if_c.out_dataV, if_b.out_dataV, if_a.out_dataV};
    assign operr = {if_c.out_parity_err, if_b.out_parity_err, if_a.out_parity_err};
    assign oferr = {if_c.out_frame_err, if_b.out_frame_err, if_a.out_frame_err};
    assign obrk  = {if_c.out_break, if_b.out_break, if_a.out_break};
    assign obyte[0] = if_a.out_byte_Rx;
    assign obyte[1] = if_b.out_byte_Rx;
    assign obyte[2] = if_c.out_byte_Rx;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } rx_exp_t;

    typedef struct packed {
        logic [1:0]  dut;
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        logic        brk;
        logic [31:0] edge_no;
    } rx_obs_t;

    rx_obs_t got_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int par_en(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int nstop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    // Frame-level reference: what the receiver must report for a given frame.
    function automatic rx_exp_t model(input int d, input logic [7:0] data,
                                      input logic par, input logic [1:0] stops);
        rx_exp_t e;
        logic    all_stops_low;
        logic    any_stop_low;
        any_stop_low  = !stops[0] || (nstop(d) == 2 && !stops[1]);
        all_stops_low = !stops[0] && (nstop(d) == 1 || !stops[1]);
        e.data = data;
        e.perr = (par_en(d) == 1) && (((^data) ^ par) != 1'b0);
        e.ferr = any_stop_low;
        e.brk  = (data == 8'h00) && (par_en(d) == 0 || !par) && all_stops_low;
        return e;
    endfunction

    // Pulse monitor: records every valid pulse with its edge number.
    logic [2:0] prev_dv = 3'b000;
    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (dv[i]) begin
                rx_obs_t o;
                check_eq("dv_single", 32'(prev_dv[i]), 32'd0);
                o.dut     = 2'(i);
                o.data    = obyte[i];
                o.perr    = operr[i];
                o.ferr    = oferr[i];
                o.brk     = obrk[i];
                o.edge_no = 32'(edge_cnt);
                got_q.push_back(o);
            end
        end
        prev_dv = dv;
    end

    // Starts and ends on a falling clock edge; back-to-back calls give zero idle gap.
    task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                              input logic [1:0] stops, input int glitch_bit, input int abort_bit);
        logic [12:0] bits;
        int          n;
        bits = '0;
        n    = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = data[i]; n++;
        end
        if (par_en(d) == 1) begin
            bits[n] = par; n++;
        end
        bits[n] = stops[0]; n++;
        if (nstop(d) == 2) begin
            bits[n] = stops[1]; n++;
        end
        start_edge = edge_cnt + 1;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < C; j++) begin
                if (b == abort_bit && j == MID) return;
                line[d] = (b == glitch_bit && j == MID + 1) ? ~bits[b] : bits[b];
                @(negedge clk);
            end
        end
        line[d] = 1'b1;
    endtask

    task automatic expect_frame(input int d, input rx_exp_t e);
        rx_obs_t o;
        int      exp_lat;
        exp_lat = (8 + par_en(d) + nstop(d)) * C + MID + 4;
        check_eq("pulse_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 0) return;
        o = got_q.pop_front();
        check_eq("dut_id", 32'(o.dut), 32'(d));
        check_eq("byte", 32'(o.data), 32'(e.data));
        check_eq("parity_err", 32'(o.perr), 32'(e.perr));
        check_eq("frame_err", 32'(o.ferr), 32'(e.ferr));
        check_eq("break", 32'(o.brk), 32'(e.brk));
        check_eq("latency", o.edge_no - 32'(start_edge), 32'(exp_lat));
        $display("rx dut%0d byte=%02h perr=%0b ferr=%0b brk=%0b lat=%0d",
                 d, o.data, o.perr, o.ferr, o.brk, o.edge_no - 32'(start_edge));
        got_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_check(input int d, input logic [7:0] data, input logic par,
                              input logic [1:0] stops, input int glitch_bit);
        send_frame(d, data, par, stops, glitch_bit, -1);
        expect_frame(d, model(d, data, par, stops));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] data;
        logic [1:0] stops;
        logic       par;

        // Reset state
        idle(4);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_dv", 32'(dv[i]), 32'd0);
            check_eq("rst_byte", 32'(obyte[i]), 32'd0);
            check_eq("rst_flags", 32'({operr[i], oferr[i], obrk[i]}), 32'd0);
        end
        rst_n = 1'b1;
        idle(2 * C);
        check_eq("idle_no_pulse", 32'(got_q.size()), 32'd0);

        // 8N1 directed byte with exact latency
        send_check(0, 8'hA5, 1'b0, 2'b11, -1);
        idle(C);

        // 8N1 random frames, occasionally with a low stop bit
        for (int k = 0; k < 10; k++) begin
            data  = 8'($urandom);
            stops = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
            send_check(0, data, 1'b0, stops, -1);
            idle(stops[0] ? $urandom_range(0, 20) : C);
        end

        // Line held low for 20 bit times: one break frame, then silence
        start_edge = edge_cnt + 1;
        line[0] = 1'b0;
        idle(20 * C);
        line[0] = 1'b1;
        idle(2 * C);
        expect_frame(0, model(0, 8'h00, 1'b0, 2'b00));
        send_check(0, 8'h3C, 1'b0, 2'b11, -1);
        idle(C);

        // False start: 4-cycle low pulse
        line[0] = 1'b0;
        idle(4);
        line[0] = 1'b1;
        idle(3 * C);
        check_eq("false_start", 32'(got_q.size()), 32'd0);
        send_check(0, 8'hC3, 1'b0, 2'b11, -1);
        idle(C);

        // Single-cycle glitch inside data bit 3 (frame bit 4)
        send_check(0, 8'h00, 1'b0, 2'b11, 4);
        idle(C);

        // 8E1 random frames, then the directed parity pair
        for (int k = 0; k < 8; k++) begin
            data = 8'($urandom);
            par  = 1'($urandom);
            send_check(1, data, par, 2'b11, -1);
            idle($urandom_range(0, 20));
        end
        send_check(1, 8'h37, 1'b1, 2'b11, -1);
        idle(C);
        send_check(1, 8'h37, 1'b0, 2'b11, -1);
        idle(C);

        // 8N2 random stop patterns, then directed frame-error recovery
        for (int k = 0; k < 6; k++) begin
            data  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            stops = 2'($urandom);
            send_check(2, data, 1'b0, stops, -1);
            idle(stops[1] ? $urandom_range(0, 20) : C);
        end
        send_check(2, 8'h5A, 1'b0, 2'b01, -1);
        idle(C);
        send_check(2, 8'h11, 1'b0, 2'b11, -1);
        idle(C);

        // Back-to-back frames, then reset in the middle of data bit 4
        send_check(0, 8'hFF, 1'b0, 2'b11, -1);
        send_check(0, 8'h00, 1'b0, 2'b11, -1);
        send_frame(0, 8'h96, 1'b0, 2'b11, -1, 5);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("midrst_dv", 32'(dv[i]), 32'd0);
            check_eq("midrst_byte", 32'(obyte[i]), 32'd0);
            check_eq("midrst_flags", 32'({operr[i], oferr[i], obrk[i]}), 32'd0);
        end
        line[0] = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(12 * C);
        check_eq("no_partial_pulse", 32'(got_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
